// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared sorter parameters and drain FSM encoding
package sort_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_OUT  = 3'd3,
    ST_FIN  = 3'd4
  } drain_state_e;

endpackage

// File: rtl/sorted_mem_drain.sv
// rtl/sorted_mem_drain.sv - streams sorted RAM 0..DEPTH-1 out, flags first descending pair
module sorted_mem_drain
  import sort_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              order_err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  drain_state_e      state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              is_last;
  logic              accept;

  assign is_last = (idx_q == LAST_IDX);
  assign accept  = (state_q == ST_OUT) && out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RD;
      ST_RD:   state_d = ST_CAP;
      ST_CAP:  state_d = ST_OUT;
      ST_OUT:  if (accept) state_d = is_last ? ST_FIN : ST_RD;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = (state_q == ST_RD);
    mem_addr  = (state_q == ST_RD) ? idx_q : '0;
    out_valid = (state_q == ST_OUT);
    out_last  = (state_q == ST_OUT) && is_last;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_FIN);
  end

  // Datapath: only the first descending pair of a drain is recorded.
  always_comb begin
    idx_d      = idx_q;
    prev_d     = prev_q;
    data_d     = data_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d      = '0;
          err_d      = 1'b0;
          err_addr_d = '0;
        end
      end
      ST_CAP: begin
        data_d = mem_rdata;
        prev_d = mem_rdata;
        if ((idx_q != '0) && (mem_rdata < prev_q) && !err_q) begin
          err_d      = 1'b1;
          err_addr_d = idx_q;
        end
      end
      ST_OUT: begin
        if (accept && !is_last) idx_d = idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q      <= '0;
      prev_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      idx_q      <= idx_d;
      prev_q     <= prev_d;
      data_q     <= data_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign out_data  = data_q;
  assign order_err = err_q;
  assign err_addr  = err_addr_q;

endmodule
